nn_layer_buffer: RTL and testbench

- Parametrised successor to the single-neuron layer memory of the MLP datapath. Holds input activations, all weights and all biases for an L-layer, N-neuron-per-layer network.
- Loaded through a streaming ready/valid port instead of whole-array ports.
- Serves registered per-neuron read bundles to the MAC.
- Tracks layer progress internally. Counts result writes, swaps ping-pong activation banks and flags network completion without external layer/neuron bookkeeping.

---
 rtl/nn_layer_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_nn_layer_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_buffer.sv
// rtl/nn_layer_buffer.sv - activation/weight/bias buffer for an L-layer, N-neuron MLP datapath
//
// Holds ping-pong activation banks, all weights and all biases. Loaded through a
// ready/valid word stream, serves registered per-neuron read bundles to the MAC,
// collects MAC results and advances layers on its own.
//
// Ports:
//   clk, nrst                  clock (rising edge), synchronous active-low reset
//   load_start                 pulse: enter LOAD with all counters cleared
//   ld_valid/ld_ready/ld_data  load word stream (x values, then per-neuron weights+bias)
//   rd_req/rd_neuron           read request for a neuron of the current layer
//   rd_valid/rd_inputs/
//   rd_weights/rd_bias         registered read bundle, rd_valid is a 1-cycle pulse
//   wr_en/wr_data              MAC result strobe and value
//   cur_layer                  layer currently being computed (L once complete)
//   busy/done                  LOAD or RUN / network complete
//   out_vec                    final activations while done=1
module nn_layer_buffer #(
  parameter int L  = 2,
  parameter int N  = 4,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 3,
  parameter int WN = 5,
  localparam int DW  = QM + QN,
  localparam int WW  = WM + WN,
  localparam int LDW = (DW > WW) ? DW : WW,
  localparam int NB  = $clog2(N),
  localparam int LB  = $clog2(L) + 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [LDW-1:0]    ld_data,
  input  logic              rd_req,
  input  logic [NB-1:0]     rd_neuron,
  output logic              rd_valid,
  output logic [N*DW-1:0]   rd_inputs,
  output logic [N*WW-1:0]   rd_weights,
  output logic [DW-1:0]     rd_bias,
  input  logic              wr_en,
  input  logic [DW-1:0]     wr_data,
  output logic [LB-1:0]     cur_layer,
  output logic              busy,
  output logic              done,
  output logic [N*DW-1:0]   out_vec
);

  // Layer index width for array addressing (cur_layer itself needs room for L).
  localparam int LIB = (L > 1) ? $clog2(L) : 1;
  // Word counter inside a neuron record: 0..N-1 weights, N = bias.
  localparam int KB  = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [DW-1:0] bank_q [2][N];
  logic [WW-1:0] w_q    [L][N][N];
  logic [DW-1:0] b_q    [L][N];

  logic            in_bank_q;
  logic            xphase_q;
  logic [KB-1:0]   ld_k_q;
  logic [NB-1:0]   ld_n_q;
  logic [LIB-1:0]  ld_l_q;
  logic [NB-1:0]   wcnt_q;
  logic [LB-1:0]   cur_layer_q;
  logic            rd_valid_q;
  logic [N*DW-1:0] rd_inputs_q;
  logic [N*WW-1:0] rd_weights_q;
  logic [DW-1:0]   rd_bias_q;

  // load_start overrides everything else in the same cycle.
  logic ld_fire, ld_last_word, run_ok, wr_fire, wr_layer_end, last_layer, rd_fire;

  assign ld_fire      = ld_valid && (state_q == S_LOAD) && !load_start;
  assign ld_last_word = !xphase_q && (ld_k_q == KB'(N)) && (ld_n_q == NB'(N - 1))
                        && (ld_l_q == LIB'(L - 1));
  assign run_ok       = (state_q == S_RUN) && !load_start;
  assign wr_fire      = wr_en && run_ok;
  assign wr_layer_end = wr_fire && (wcnt_q == NB'(N - 1));
  assign last_layer   = (cur_layer_q == LB'(L - 1));
  assign rd_fire      = rd_req && run_ok;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (ld_fire && ld_last_word) state_d = S_RUN;
        S_RUN:   if (wr_layer_end && last_layer) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    ld_ready = (state_q == S_LOAD);
    busy     = (state_q == S_LOAD) || (state_q == S_RUN);
    done     = (state_q == S_DONE);
  end

  // The final swap leaves the bank just written as the input bank.
  always_comb begin
    out_vec = '0;
    if (done) begin
      for (int i = 0; i < N; i++) out_vec[i*DW +: DW] = bank_q[in_bank_q][i];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N; i++) bank_q[b][i] <= '0;
      for (int l = 0; l < L; l++)
        for (int n = 0; n < N; n++) begin
          b_q[l][n] <= '0;
          for (int k = 0; k < N; k++) w_q[l][n][k] <= '0;
        end
      in_bank_q    <= 1'b0;
      xphase_q     <= 1'b1;
      ld_k_q       <= '0;
      ld_n_q       <= '0;
      ld_l_q       <= '0;
      wcnt_q       <= '0;
      cur_layer_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_inputs_q  <= '0;
      rd_weights_q <= '0;
      rd_bias_q    <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (load_start) begin
        xphase_q    <= 1'b1;
        ld_k_q      <= '0;
        ld_n_q      <= '0;
        ld_l_q      <= '0;
        wcnt_q      <= '0;
        cur_layer_q <= '0;
        in_bank_q   <= 1'b0;
      end else begin
        if (ld_fire) begin
          if (xphase_q) begin
            bank_q[0][ld_k_q[NB-1:0]] <= ld_data[DW-1:0];
            if (ld_k_q == KB'(N - 1)) begin
              xphase_q <= 1'b0;
              ld_k_q   <= '0;
            end else begin
              ld_k_q <= ld_k_q + 1'b1;
            end
          end else if (ld_k_q == KB'(N)) begin
            b_q[ld_l_q][ld_n_q] <= ld_data[DW-1:0];
            ld_k_q <= '0;
            if (ld_n_q == NB'(N - 1)) begin
              ld_n_q <= '0;
              ld_l_q <= ld_l_q + 1'b1;
            end else begin
              ld_n_q <= ld_n_q + 1'b1;
            end
          end else begin
            w_q[ld_l_q][ld_n_q][ld_k_q[NB-1:0]] <= ld_data[WW-1:0];
            ld_k_q <= ld_k_q + 1'b1;
          end
        end
        if (wr_fire) begin
          bank_q[~in_bank_q][wcnt_q] <= wr_data;
          if (wr_layer_end) begin
            wcnt_q      <= '0;
            in_bank_q   <= ~in_bank_q;
            cur_layer_q <= cur_layer_q + 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
      end
      // Captured from pre-update state, so a read coinciding with the last
      // write of a layer still sees the old bank and the old layer.
      if (rd_fire) begin
        for (int i = 0; i < N; i++) begin
          rd_inputs_q[i*DW +: DW]  <= bank_q[in_bank_q][i];
          rd_weights_q[i*WW +: WW] <= w_q[cur_layer_q[LIB-1:0]][rd_neuron][i];
        end
        rd_bias_q <= b_q[cur_layer_q[LIB-1:0]][rd_neuron];
      end
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_inputs  = rd_inputs_q;
  assign rd_weights = rd_weights_q;
  assign rd_bias    = rd_bias_q;
  assign cur_layer  = cur_layer_q;

endmodule

// File: tb/tb_nn_layer_buffer.sv
// tb/tb_nn_layer_buffer.sv - directed self-checking bench for nn_layer_buffer
module tb_nn_layer_buffer;

  logic        clk = 1'b0;
  logic        nrst;
  logic        load_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        rd_req;
  logic [1:0]  rd_neuron;
  logic        rd_valid;
  logic [31:0] rd_inputs;
  logic [31:0] rd_weights;
  logic [7:0]  rd_bias;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic [1:0]  cur_layer;
  logic        busy;
  logic        done;
  logic [31:0] out_vec;

  int checks   = 0;
  int failures = 0;

  nn_layer_buffer dut (
    .clk        (clk),
    .nrst       (nrst),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .rd_req     (rd_req),
    .rd_neuron  (rd_neuron),
    .rd_valid   (rd_valid),
    .rd_inputs  (rd_inputs),
    .rd_weights (rd_weights),
    .rd_bias    (rd_bias),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .cur_layer  (cur_layer),
    .busy       (busy),
    .done       (done),
    .out_vec    (out_vec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Weight/bias contents loaded for every test: w[0][1]={1,2,3,4}, b[0][1]=8.
  function automatic logic [7:0] wv(input int l, input int n, input int k);
    return 8'(l * 64 + (n - 1) * 16 + k + 1);
  endfunction

  function automatic logic [7:0] bv(input int l, input int n);
    return 8'(l * 48 + n * 8);
  endfunction

  task automatic send(input logic [7:0] d, input bit gap);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic do_load(input logic [31:0] xv, input bit gap);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready", ld_ready, 1);
    chk("load_cur_layer", cur_layer, 0);
    for (int k = 0; k < 4; k++) send(xv[k*8 +: 8], gap);
    for (int l = 0; l < 2; l++)
      for (int n = 0; n < 4; n++) begin
        for (int k = 0; k < 4; k++) send(wv(l, n, k), gap);
        send(bv(l, n), gap);
      end
    chk("run_busy", busy, 1);
    chk("run_ld_ready", ld_ready, 0);
    chk("run_done", done, 0);
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] n);
    rd_req    = 1'b1;
    rd_neuron = n;
    tick();
    rd_req    = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    rd_req = 1'b0; rd_neuron = '0; wr_en = 1'b0; wr_data = '0;
    tick(); tick();
    nrst = 1'b1;
    tick();

    // Idle: reads and writes ignored
    chk("idle_busy", busy, 0);
    do_read(2'd1);
    chk("idle_rd_valid", rd_valid, 0);

    // First load and read of neuron 1, layer 0
    do_load(32'h00F01020, 1'b0);
    do_read(2'd1);
    chk("rd0_valid", rd_valid, 1);
    chk("rd0_inputs", rd_inputs, 32'h00F01020);
    chk("rd0_weights", rd_weights, 32'h04030201);
    chk("rd0_bias", rd_bias, 8'h08);
    tick();
    chk("rd0_pulse", rd_valid, 0);
    chk("rd0_hold", rd_weights, 32'h04030201);

    // Reset mid-LOAD
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0);
    nrst = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_inputs", rd_inputs, 0);
    chk("rst_rd_weights", rd_weights, 0);
    chk("rst_rd_bias", rd_bias, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_cur_layer", cur_layer, 0);

    // Reload, then layer 0 writes with a read on the final write
    do_load(32'h00F01020, 1'b0);
    do_write(8'h11); do_write(8'h22); do_write(8'h33);
    chk("l0_mid_layer", cur_layer, 0);
    rd_req = 1'b1; rd_neuron = 2'd2;
    do_write(8'h44);
    rd_req = 1'b0;
    chk("coinc_valid", rd_valid, 1);
    chk("coinc_inputs", rd_inputs, 32'h00F01020);
    chk("coinc_weights", rd_weights, 32'h14131211);
    chk("coinc_bias", rd_bias, 8'h10);
    chk("l1_cur_layer", cur_layer, 1);
    do_read(2'd2);
    chk("l1_inputs", rd_inputs, 32'h44332211);
    chk("l1_weights", rd_weights, 32'h54535251);
    chk("l1_bias", rd_bias, 8'h40);

    // Layer 1 writes complete the network
    do_write(8'h05); do_write(8'h06); do_write(8'h07);
    chk("l1_not_done", done, 0);
    do_write(8'h08);
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    chk("done_out_vec", out_vec, 32'h08070605);
    chk("done_cur_layer", cur_layer, 2);
    wr_en = 1'b1; wr_data = 8'h99; rd_req = 1'b1; rd_neuron = 2'd0;
    tick();
    wr_en = 1'b0; rd_req = 1'b0;
    chk("done_rd_ignored", rd_valid, 0);
    chk("done_wr_ignored", out_vec, 32'h08070605);
    chk("done_held", done, 1);

    // Gapped load (restarts from DONE)
    do_load(32'h04030201, 1'b1);
    chk("gap_cleared_done", done, 0);
    do_read(2'd3);
    chk("gap_inputs", rd_inputs, 32'h04030201);
    chk("gap_weights", rd_weights, 32'h24232221);
    chk("gap_bias", rd_bias, 8'h18);

    // load_start mid-RUN wins over concurrent write and read
    do_write(8'hA1); do_write(8'hA2);
    load_start = 1'b1; wr_en = 1'b1; wr_data = 8'hA3; rd_req = 1'b1; rd_neuron = 2'd0;
    tick();
    load_start = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_ld_ready", ld_ready, 1);
    chk("abort_cur_layer", cur_layer, 0);
    do_load(32'h0D0C0B0A, 1'b0);
    do_write(8'h61); do_write(8'h62); do_write(8'h63); do_write(8'h64);
    chk("re_cur_layer", cur_layer, 1);
    do_read(2'd0);
    chk("re_inputs", rd_inputs, 32'h64636261);
    chk("re_weights", rd_weights, 32'h34333231);
    chk("re_bias", rd_bias, 8'h30);
    do_write(8'h71); do_write(8'h72); do_write(8'h73); do_write(8'h74);
    chk("re_done", done, 1);
    chk("re_out_vec", out_vec, 32'h74737271);
    chk("re_final_layer", cur_layer, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
